bist_sram_responder: RTL and testbench
======================================

# bist_sram_responder

Single-port synchronous SRAM responder with a programmable fault table, serving as the memory end of the BIST access interface. The `bist` controller (initiator) issues reads and writes; this block stores data, applies injected stuck-at and transition faults, and returns read data one cycle later. It lets directed benches confirm that `bist` raises `bist_fail` for a faulty array and finishes clean for a fault-free one.

## Interface
Parameters:
- `ADDR_W`, 6, address width; depth = 2^ADDR_W words.
- `DATA_W`, 8, word width.
- `NUM_FAULTS`, 4, fault-table entries.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_cs`  in  1  access request, sampled each cycle.
- `mem_we`  in  1  1 = write, 0 = read; qualified by `mem_cs`.
- `mem_addr`  in  ADDR_W  access address.
- `mem_wdata`  in  DATA_W  write data.
- `mem_rdata`  out  DATA_W  registered read data.
- `mem_rvalid`  out  1  one-cycle pulse marking valid `mem_rdata`.
- `mem_ready`  out  1  1 = accesses accepted; 0 during init.
- `flt_wr`  in  1  write one fault-table entry.
- `flt_idx`  in  clog2(NUM_FAULTS)  entry index.
- `flt_addr`  in  ADDR_W  faulty word address.
- `flt_bit`  in  clog2(DATA_W)  faulty bit position.
- `flt_type`  in  2  00 none, 01 SA0, 10 SA1, 11 TF_UP (bit cannot rise 0->1).
- `rd_cnt`, `wr_cnt`  out  16  saturating counts of accepted reads/writes.

## Operation
- States: INIT and READY. Reset always enters INIT, clears the init pointer, all fault entries (type none), `rd_cnt`, `wr_cnt`, `mem_rdata`, and `mem_rvalid`.
- INIT:
  - Writes 0 to word[ptr] and increments ptr once per cycle.
  - After writing word 2^ADDR_W-1, goes to READY on the next edge (INIT lasts exactly 2^ADDR_W cycles).
  - `mem_ready`=0. `mem_cs` is ignored: no store, no `rvalid`, no count.
- READY: `mem_ready`=1 and `mem_cs` is honoured every cycle (no back-pressure).
- Fault matching:
  - An entry matches bit b of word a when type≠none, `flt_addr`=a and `flt_bit`=b.
  - If several entries match, the lowest index wins.
- Write:
  - Per bit, stored value = SA0→0; SA1→1; TF_UP→old value if old=0 and new=1, else new; no fault→new.
  - Increments `wr_cnt`.
- Read:
  - `mem_rdata` = stored word with SA0/SA1 bits forced again (covers faults added after the data was written).
  - `mem_rvalid`=1 for one cycle. Increments `rd_cnt`.
- Fault table:
  - `flt_wr` updates entry `flt_idx` at the clock edge in any state.
  - An access in the same cycle uses the old table.
- Counters saturate at 0xFFFF.

## Timing
- Reset values: `mem_rdata`=0, `mem_rvalid`=0, `mem_ready`=0, `rd_cnt`=0, `wr_cnt`=0.
- Read latency:
  - Request in cycle N → `mem_rdata`/`mem_rvalid` valid in cycle N+1.
  - `mem_rdata` holds its value until the next read; `mem_rvalid` returns to 0 unless another read occurred in cycle N+1.
- Write in cycle N is visible to a read in cycle N+1 (data returned in N+2).
- Back-to-back reads: one result per cycle, in order.
- `mem_ready` rises 2^ADDR_W cycles after the first cycle with `rst` low.
- `rst` asserted mid-INIT or mid-READY:
  - Restarts INIT from ptr 0.
  - A read issued in the cycle `rst` is high produces no `rvalid`.
- Address wrap: none; every address is legal.

## Test plan
- Reset, then idle → `mem_ready` rises after exactly 64 cycles (ADDR_W=6). Read of every address returns 0x00 with `rvalid` one cycle after each request; `rd_cnt`=64.
- No faults, write 0x55 to addr 10 then read 10 → `mem_rdata`=0x55 next cycle. Repeat with 0xAA → 0xAA; `wr_cnt`=2, `rd_cnt`=2.
- Entry 0 = SA1 at addr 3 bit 0 → write 0x00 then read addr 3 → 0x01. Entry 1 = SA0 at addr 3 bit 0 → read still 0x01 (lowest index wins).
- Entry 2 = TF_UP at addr 7 bit 7 → write 0x00 then 0xFF to addr 7 → reads 0x7F. Clear the entry (type 00), write 0xFF → reads 0xFF.
- `flt_wr` (SA0 at addr 5 bit 1) in the same cycle as a write of 0x02 to addr 5 → read returns 0x00. Old-table rule: the stored value is 0x02, but the new SA0 forces bit 1 on read.
- Assert `rst` for one cycle mid-READY while issuing a read → no `rvalid`, counters=0, `mem_ready`=0, memory re-zeroed, `mem_ready` high again after 64 cycles.

Source files
------------

// File: rtl/bist_sram_responder.sv
// SRAM responder for the BIST access interface: zero-initialises the array after
// reset and applies a programmable table of stuck-at / transition faults to accesses.
module bist_sram_responder #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int NUM_FAULTS = 4,
    localparam int IDX_W     = $clog2(NUM_FAULTS),
    localparam int BIT_W     = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_cs,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rvalid,
    output logic              mem_ready,
    input  logic              flt_wr,
    input  logic [IDX_W-1:0]  flt_idx,
    input  logic [ADDR_W-1:0] flt_addr,
    input  logic [BIT_W-1:0]  flt_bit,
    input  logic [1:0]        flt_type,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] FLT_NONE = 2'b00;
    localparam logic [1:0] FLT_SA0  = 2'b01;
    localparam logic [1:0] FLT_SA1  = 2'b10;
    localparam logic [1:0] FLT_TFU  = 2'b11;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [1:0]        tbl_type_r [NUM_FAULTS];
    logic [ADDR_W-1:0] tbl_addr_r [NUM_FAULTS];
    logic [BIT_W-1:0]  tbl_bit_r  [NUM_FAULTS];

    logic [1:0]        sel_s;
    logic [DATA_W-1:0] sa0_s;
    logic [DATA_W-1:0] sa1_s;
    logic [DATA_W-1:0] tfu_s;
    logic              acc_s;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic              init_wr_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_wa_s;
    logic [DATA_W-1:0] mem_wd_s;
    logic [DATA_W-1:0] old_s;

    // Per-bit fault masks for the accessed word; scanning high-to-low lets the lowest index win
    always_comb begin
        sel_s = FLT_NONE;
        sa0_s = '0;
        sa1_s = '0;
        tfu_s = '0;
        for (int b = 0; b < DATA_W; b++) begin
            sel_s = FLT_NONE;
            for (int i = NUM_FAULTS - 1; i >= 0; i--) begin
                if ((tbl_type_r[i] != FLT_NONE) && (tbl_addr_r[i] == mem_addr) &&
                    (tbl_bit_r[i] == BIT_W'(b))) begin
                    sel_s = tbl_type_r[i];
                end else begin
                    sel_s = sel_s;
                end
            end
            case (sel_s)
                FLT_SA0: sa0_s[b] = 1'b1;
                FLT_SA1: sa1_s[b] = 1'b1;
                FLT_TFU: tfu_s[b] = 1'b1;
                default: ;
            endcase
        end
    end

    // Access qualification and array write-port selection (init sweep vs. faulted write)
    always_comb begin
        old_s     = mem_r[mem_addr];
        acc_s     = !rst && (state_r == ST_READY) && mem_cs;
        rd_acc_s  = acc_s && !mem_we;
        wr_acc_s  = acc_s && mem_we;
        init_wr_s = !rst && (state_r == ST_INIT);
        mem_we_s  = init_wr_s || wr_acc_s;
        if (init_wr_s) begin
            mem_wa_s = ptr_r;
            mem_wd_s = '0;
        end else begin
            mem_wa_s = mem_addr;
            // A TF_UP bit keeps its old 0 when asked to rise; stuck-at bits override everything
            mem_wd_s = ((mem_wdata & ~(tfu_s & ~old_s)) & ~sa0_s) | sa1_s;
        end
    end

    // Storage array (no reset: contents are cleared by the INIT sweep)
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end

    // Fault table; an access in the same cycle still sees the previous entries
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FAULTS; i++) begin
                tbl_type_r[i] <= FLT_NONE;
                tbl_addr_r[i] <= '0;
                tbl_bit_r[i]  <= '0;
            end
        end else if (flt_wr) begin
            tbl_type_r[flt_idx] <= flt_type;
            tbl_addr_r[flt_idx] <= flt_addr;
            tbl_bit_r[flt_idx]  <= flt_bit;
        end
    end

    // Control FSM, read pipeline register and saturating access counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_INIT;
            ptr_r      <= '0;
            mem_ready  <= 1'b0;
            mem_rdata  <= '0;
            mem_rvalid <= 1'b0;
            rd_cnt     <= 16'd0;
            wr_cnt     <= 16'd0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    ptr_r <= ptr_r + ADDR_W'(1);
                    if (ptr_r == {ADDR_W{1'b1}}) begin
                        state_r   <= ST_READY;
                        mem_ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    mem_ready <= 1'b1;
                end
                default: begin
                    state_r   <= ST_INIT;
                    ptr_r     <= '0;
                    mem_ready <= 1'b0;
                end
            endcase
            mem_rvalid <= rd_acc_s;
            if (rd_acc_s) begin
                mem_rdata <= (old_s & ~sa0_s) | sa1_s;
            end
            if (rd_acc_s && (rd_cnt != 16'hFFFF)) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
            if (wr_acc_s && (wr_cnt != 16'hFFFF)) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bist_sram_responder.sv
// Directed self-checking bench for bist_sram_responder: init timing, read/write,
// fault table semantics and mid-operation reset.
module tb_bist_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_cs;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic        mem_ready;
    logic        flt_wr;
    logic [1:0]  flt_idx;
    logic [5:0]  flt_addr;
    logic [2:0]  flt_bit;
    logic [1:0]  flt_type;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    int checks = 0;
    int passed = 0;
    int exp_rd = 0;
    int exp_wr = 0;

    bist_sram_responder #(.ADDR_W(6), .DATA_W(8), .NUM_FAULTS(4)) dut (
        .clk(clk), .rst(rst), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_ready(mem_ready), .flt_wr(flt_wr), .flt_idx(flt_idx), .flt_addr(flt_addr),
        .flt_bit(flt_bit), .flt_type(flt_type), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        mem_cs = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = d;
        tick();
        mem_cs = 1'b0;
        exp_wr++;
    endtask

    task automatic rd(input logic [5:0] a);
        mem_cs = 1'b1; mem_we = 1'b0; mem_addr = a;
        tick();
        mem_cs = 1'b0;
        exp_rd++;
    endtask

    task automatic set_flt(input logic [1:0] idx, input logic [5:0] a, input logic [2:0] b,
                           input logic [1:0] t);
        flt_wr = 1'b1; flt_idx = idx; flt_addr = a; flt_bit = b; flt_type = t;
        tick();
        flt_wr = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (mem_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        int bad;
        rst = 1'b1; mem_cs = 1'b0; mem_we = 1'b0; mem_addr = 6'd0; mem_wdata = 8'h00;
        flt_wr = 1'b0; flt_idx = 2'd0; flt_addr = 6'd0; flt_bit = 3'd0; flt_type = 2'b00;
        tick();
        tick();
        checks++;
        if ({mem_ready, mem_rvalid, mem_rdata} !== 10'd0)
            $display("FAIL reset_outputs: got ready=%b rvalid=%b rdata=%h want 0/0/00",
                     mem_ready, mem_rvalid, mem_rdata);
        else passed++;
        checks++;
        if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0)
            $display("FAIL reset_counters: got rd=%0d wr=%0d want 0/0", rd_cnt, wr_cnt);
        else passed++;
        // Hammer the port during INIT: accesses must be ignored entirely
        rst = 1'b0; mem_cs = 1'b1; mem_addr = 6'd0; mem_wdata = 8'hFF;
        n = 0; bad = 0;
        while (mem_ready !== 1'b1 && n < 200) begin
            mem_we = n[0];
            tick();
            n++;
            if (mem_rvalid !== 1'b0) bad++;
        end
        mem_cs = 1'b0;
        checks++;
        if (n !== 64) $display("FAIL init_length: got %0d cycles want 64", n);
        else passed++;
        checks++;
        if (bad !== 0 || rd_cnt !== 16'd0 || wr_cnt !== 16'd0)
            $display("FAIL init_ignores_cs: got rvalids=%0d rd=%0d wr=%0d want 0/0/0",
                     bad, rd_cnt, wr_cnt);
        else passed++;
    endtask

    task automatic test_read_all();
        int bad = 0;
        mem_cs = 1'b1; mem_we = 1'b0;
        for (int a = 0; a < 64; a++) begin
            mem_addr = a[5:0];
            tick();
            exp_rd++;
            if (mem_rvalid !== 1'b1 || mem_rdata !== 8'h00) bad++;
        end
        mem_cs = 1'b0;
        checks++;
        if (bad !== 0) $display("FAIL read_all_zero: got %0d bad words want 0", bad);
        else passed++;
        tick();
        checks++;
        if (mem_rvalid !== 1'b0) $display("FAIL rvalid_pulse: got %b want 0", mem_rvalid);
        else passed++;
        checks++;
        if (rd_cnt !== 16'd64) $display("FAIL rd_cnt_64: got %0d want 64", rd_cnt);
        else passed++;
    endtask

    task automatic test_basic_rw();
        wr(6'd10, 8'h55);
        checks++;
        if (mem_rvalid !== 1'b0) $display("FAIL write_no_rvalid: got %b want 0", mem_rvalid);
        else passed++;
        rd(6'd10);
        checks++;
        if (mem_rvalid !== 1'b1 || mem_rdata !== 8'h55)
            $display("FAIL rw_55: got %b/%h want 1/55", mem_rvalid, mem_rdata);
        else passed++;
        wr(6'd10, 8'hAA);
        rd(6'd10);
        checks++;
        if (mem_rvalid !== 1'b1 || mem_rdata !== 8'hAA)
            $display("FAIL rw_aa: got %b/%h want 1/aa", mem_rvalid, mem_rdata);
        else passed++;
        tick();
        checks++;
        if (mem_rvalid !== 1'b0 || mem_rdata !== 8'hAA)
            $display("FAIL rdata_hold: got %b/%h want 0/aa", mem_rvalid, mem_rdata);
        else passed++;
        checks++;
        if (wr_cnt !== 16'd2 || rd_cnt !== 16'd66)
            $display("FAIL basic_counts: got wr=%0d rd=%0d want 2/66", wr_cnt, rd_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] addrs [3];
        logic [7:0] vals  [3];
        addrs[0] = 6'd1; addrs[1] = 6'd2; addrs[2] = 6'd63;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'hC3;
        for (int i = 0; i < 3; i++) wr(addrs[i], vals[i]);
        mem_cs = 1'b1; mem_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_addr = addrs[i];
            tick();
            exp_rd++;
            checks++;
            if (mem_rvalid !== 1'b1 || mem_rdata !== vals[i])
                $display("FAIL b2b_read%0d: got %b/%h want 1/%h", i, mem_rvalid, mem_rdata, vals[i]);
            else passed++;
        end
        mem_cs = 1'b0;
    endtask

    task automatic test_faults();
        set_flt(2'd0, 6'd3, 3'd0, 2'b10);
        wr(6'd3, 8'h00);
        rd(6'd3);
        checks++;
        if (mem_rdata !== 8'h01) $display("FAIL sa1: got %h want 01", mem_rdata);
        else passed++;
        set_flt(2'd1, 6'd3, 3'd0, 2'b01);
        rd(6'd3);
        checks++;
        if (mem_rdata !== 8'h01) $display("FAIL lowest_index: got %h want 01", mem_rdata);
        else passed++;
        rd(6'd10);
        checks++;
        if (mem_rdata !== 8'hAA) $display("FAIL other_addr: got %h want aa", mem_rdata);
        else passed++;
        set_flt(2'd2, 6'd7, 3'd7, 2'b11);
        wr(6'd7, 8'h00);
        wr(6'd7, 8'hFF);
        rd(6'd7);
        checks++;
        if (mem_rdata !== 8'h7F) $display("FAIL tf_up: got %h want 7f", mem_rdata);
        else passed++;
        set_flt(2'd2, 6'd7, 3'd7, 2'b00);
        wr(6'd7, 8'hFF);
        rd(6'd7);
        checks++;
        if (mem_rdata !== 8'hFF) $display("FAIL tf_cleared: got %h want ff", mem_rdata);
        else passed++;
        // Table update and write in the same cycle: the write sees the old (empty) entry
        flt_wr = 1'b1; flt_idx = 2'd3; flt_addr = 6'd5; flt_bit = 3'd1; flt_type = 2'b01;
        mem_cs = 1'b1; mem_we = 1'b1; mem_addr = 6'd5; mem_wdata = 8'h02;
        tick();
        flt_wr = 1'b0; mem_cs = 1'b0; exp_wr++;
        rd(6'd5);
        checks++;
        if (mem_rdata !== 8'h00) $display("FAIL same_cycle_sa0_read: got %h want 00", mem_rdata);
        else passed++;
        set_flt(2'd3, 6'd5, 3'd1, 2'b00);
        rd(6'd5);
        checks++;
        if (mem_rdata !== 8'h02) $display("FAIL same_cycle_stored: got %h want 02", mem_rdata);
        else passed++;
        set_flt(2'd3, 6'd5, 3'd1, 2'b01);
        wr(6'd5, 8'hFF);
        set_flt(2'd3, 6'd5, 3'd1, 2'b00);
        rd(6'd5);
        checks++;
        if (mem_rdata !== 8'hFD) $display("FAIL sa0_on_write: got %h want fd", mem_rdata);
        else passed++;
        checks++;
        if (rd_cnt !== 16'(exp_rd) || wr_cnt !== 16'(exp_wr))
            $display("FAIL fault_counts: got rd=%0d wr=%0d want %0d/%0d", rd_cnt, wr_cnt, exp_rd, exp_wr);
        else passed++;
    endtask

    task automatic test_rst_mid();
        int n;
        wr(6'd20, 8'h3C);
        rd(6'd20);
        checks++;
        if (mem_rdata !== 8'h3C) $display("FAIL pre_rst_data: got %h want 3c", mem_rdata);
        else passed++;
        rst = 1'b1; mem_cs = 1'b1; mem_we = 1'b0; mem_addr = 6'd20;
        tick();
        rst = 1'b0; mem_cs = 1'b0;
        checks++;
        if (mem_rvalid !== 1'b0 || mem_ready !== 1'b0 || rd_cnt !== 16'd0 || wr_cnt !== 16'd0)
            $display("FAIL rst_mid_ready: got rvalid=%b ready=%b rd=%0d wr=%0d want 0/0/0/0",
                     mem_rvalid, mem_ready, rd_cnt, wr_cnt);
        else passed++;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(n);
        checks++;
        if (n !== 64) $display("FAIL rst_mid_init_length: got %0d cycles want 64", n);
        else passed++;
        rd(6'd20);
        checks++;
        if (mem_rvalid !== 1'b1 || mem_rdata !== 8'h00)
            $display("FAIL rezeroed: got %b/%h want 1/00", mem_rvalid, mem_rdata);
        else passed++;
        rd(6'd3);
        checks++;
        if (mem_rdata !== 8'h00) $display("FAIL faults_cleared: got %h want 00", mem_rdata);
        else passed++;
        checks++;
        if (rd_cnt !== 16'd2) $display("FAIL post_rst_rd_cnt: got %0d want 2", rd_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_read_all();
        test_basic_rw();
        test_back_to_back();
        test_faults();
        test_rst_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
